mac_unit: RTL

- Pipelined multiply-accumulate stage that sits directly downstream of the combinational mulxx multiplier and consumes its 18-bit shifted product.
- Registers the operands, drives mulxx, and accumulates the product into a wide saturating accumulator.
- Presents a saturated WORD_SIZE result to the processor execute stage over a valid/ready handshake.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_unit_mulxx.sv | 29 ++
 rtl/mac_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared opcodes, limits and saturation helper for the MAC pipeline.
package mac_pkg;

    localparam logic [1:0] MAC_OP_MUL = 2'd0;
    localparam logic [1:0] MAC_OP_MAC = 2'd1;
    localparam logic [1:0] MAC_OP_MSU = 2'd2;
    localparam logic [1:0] MAC_OP_CLR = 2'd3;

    localparam int unsigned MAC_SHIFT_MAX = 18;

    // Clamp a signed value into the signed range of a given bit width.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                     input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/mac_unit_mulxx.sv
// Combinational multiplier with per-operand signedness and a right-shifted,
// truncated WORD_SIZE product.
module mulxx #(
    parameter int unsigned WORD_SIZE = 18
) (
    input  logic [WORD_SIZE-1:0] x,
    input  logic [WORD_SIZE-1:0] y,
    input  logic                 signx,
    input  logic                 signy,
    input  logic [4:0]           shift,
    output logic [WORD_SIZE-1:0] res
);

    // Two guard bits keep a mixed signed/unsigned product exact.
    localparam int unsigned PW = 2 * WORD_SIZE + 2;

    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    logic signed [PW-1:0] full;

    // Extend operands, multiply, arithmetic-shift and truncate.
    always_comb begin
        xe   = {{(PW - WORD_SIZE){signx & x[WORD_SIZE-1]}}, x};
        ye   = {{(PW - WORD_SIZE){signy & y[WORD_SIZE-1]}}, y};
        full = xe * ye;
        res  = WORD_SIZE'(full >>> shift);
    end

endmodule

// File: rtl/mac_unit.sv
// Two-stage multiply-accumulate: S1 holds the command and feeds mulxx,
// OUT holds the saturating accumulator and the clamped result.
module mac_unit
    import mac_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 18,
    parameter int unsigned ACC_SIZE  = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] r0,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [4:0]           shift,
    input  logic                 signx,
    input  logic                 signy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] res,
    output logic                 acc_ovf
);

    localparam int unsigned SUM_W = ACC_SIZE + 1;

    logic                        s1_valid;
    logic [1:0]                  s1_op;
    logic [WORD_SIZE-1:0]        s1_r0;
    logic [WORD_SIZE-1:0]        s1_r1;
    logic [4:0]                  s1_shift;
    logic                        s1_signx;
    logic                        s1_signy;

    logic signed [ACC_SIZE-1:0]  acc;
    logic [WORD_SIZE-1:0]        prod;

    logic                        advance;
    logic                        accept;
    logic                        sext;
    logic signed [ACC_SIZE-1:0]  p_ext;
    logic signed [SUM_W-1:0]     acc_w;
    logic signed [SUM_W-1:0]     p_w;
    logic signed [SUM_W-1:0]     sum;
    logic signed [63:0]          sum_sat;
    logic signed [ACC_SIZE-1:0]  acc_next;
    logic                        ovf_base;
    logic                        ovf_next;
    logic [WORD_SIZE-1:0]        res_next;

    mulxx #(
        .WORD_SIZE (WORD_SIZE)
    ) u_mulxx (
        .x     (s1_r0),
        .y     (s1_r1),
        .signx (s1_signx),
        .signy (s1_signy),
        .shift (s1_shift),
        .res   (prod)
    );

    // Handshake: OUT can take a new value unless it is holding one under backpressure.
    always_comb begin
        advance  = !out_valid || out_ready;
        in_ready = !s1_valid || advance;
        accept   = in_valid && in_ready;
    end

    // Extend the product, apply the op at ACC_SIZE+1 bits and saturate twice.
    always_comb begin
        sext     = s1_signx | s1_signy;
        p_ext    = {{(ACC_SIZE - WORD_SIZE){sext & prod[WORD_SIZE-1]}}, prod};
        acc_w    = SUM_W'(acc);
        p_w      = SUM_W'(p_ext);
        sum      = '0;
        ovf_base = acc_ovf;
        case (s1_op)
            MAC_OP_MUL: begin
                sum      = p_w;
                ovf_base = 1'b0;
            end
            MAC_OP_MAC: sum = acc_w + p_w;
            MAC_OP_MSU: sum = acc_w - p_w;
            default: begin
                sum      = '0;
                ovf_base = 1'b0;
            end
        endcase
        sum_sat  = saturate(64'(sum), ACC_SIZE);
        acc_next = ACC_SIZE'(sum_sat);
        ovf_next = ovf_base | (sum_sat != 64'(sum));
        res_next = WORD_SIZE'(saturate(64'(acc_next), WORD_SIZE));
    end

    // Pipeline registers: S1 refills whenever it can, OUT loads when S1 is full and OUT can advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_op     <= MAC_OP_MUL;
            s1_r0     <= '0;
            s1_r1     <= '0;
            s1_shift  <= '0;
            s1_signx  <= 1'b0;
            s1_signy  <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            res       <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_op    <= op;
                s1_r0    <= r0;
                s1_r1    <= r1;
                s1_shift <= (shift > 5'(MAC_SHIFT_MAX)) ? 5'(MAC_SHIFT_MAX) : shift;
                s1_signx <= signx;
                s1_signy <= signy;
            end
            if (s1_valid && advance) begin
                out_valid <= 1'b1;
                acc       <= acc_next;
                res       <= res_next;
                acc_ovf   <= ovf_next;
            end else if (advance) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
